// File: rtl/morse_serializer_if.sv
// Handshake/data bundle for morse_serializer.
// Master drives requests; slave returns status and the serial line.
interface morse_serializer_if #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic             ready;
  logic             busy;
  logic             morse_code;
  logic             done;

  modport master (
    output start, abort, pattern, length,
    input  ready, busy, morse_code, done
  );

  modport slave (
    input  start, abort, pattern, length,
    output ready, busy, morse_code, done
  );
endinterface

// File: rtl/morse_serializer.sv
// Morse/on-off keying serializer: shifts a captured pattern out
// MSB first, one unit per TICK_DIV cycles, then a fixed low gap.
module morse_serializer #(
  parameter int PAT_W     = 16,
  parameter int LEN_W     = 5,
  parameter int TICK_DIV  = 25000000,
  parameter int GAP_UNITS = 3
) (
  input  logic                clock,
  input  logic                reset,
  morse_serializer_if.slave   bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           r_state, w_state;
  logic [TW-1:0]    r_tick, w_tick;
  logic [PAT_W-1:0] r_pat, w_pat;
  logic [LEN_W-1:0] r_rem, w_rem, w_eff;
  logic [GW-1:0]    r_gap, w_gap;
  logic             r_code, w_code;
  logic             r_done, w_done;
  logic             w_wrap, w_last_gap;

  assign w_wrap     = (r_tick == TW'(TICK_DIV - 1));
  assign w_last_gap = (int'(r_gap) == GAP_UNITS - 1);
  assign w_eff      = (int'(bus.length) > PAT_W) ?
                      LEN_W'(PAT_W) : bus.length;

  assign bus.ready      = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.morse_code = r_code;
  assign bus.done       = r_done;

  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_pat   = r_pat;
    w_rem   = r_rem;
    w_gap   = r_gap;
    w_code  = r_code;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tick = '0;
        w_code = 1'b0;
        if (bus.start && (bus.length != '0)) begin
          w_state = SEND;
          w_pat   = bus.pattern;
          w_rem   = w_eff;
          w_code  = bus.pattern[PAT_W-1];
        end
      end
      SEND: begin
        w_tick = w_wrap ? '0 : r_tick + TW'(1);
        // abort wins over a coincident unit boundary
        if (bus.abort) begin
          w_state = IDLE;
          w_tick  = '0;
          w_pat   = '0;
          w_rem   = '0;
          w_gap   = '0;
          w_code  = 1'b0;
        end else if (w_wrap) begin
          if (r_rem == LEN_W'(1)) begin
            w_pat  = '0;
            w_rem  = '0;
            w_gap  = '0;
            w_code = 1'b0;
            if (GAP_UNITS > 0) begin
              w_state = GAP;
            end else begin
              w_state = IDLE;
              w_done  = 1'b1;
            end
          end else begin
            w_pat  = r_pat << 1;
            w_rem  = r_rem - LEN_W'(1);
            w_code = r_pat[PAT_W-2];
          end
        end
      end
      GAP: begin
        w_tick = w_wrap ? '0 : r_tick + TW'(1);
        w_code = 1'b0;
        if (bus.abort) begin
          w_state = IDLE;
          w_tick  = '0;
          w_gap   = '0;
        end else if (w_wrap) begin
          if (w_last_gap) begin
            w_state = IDLE;
            w_gap   = '0;
            w_done  = 1'b1;
          end else begin
            w_gap = r_gap + GW'(1);
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_tick  = '0;
        w_pat   = '0;
        w_rem   = '0;
        w_gap   = '0;
        w_code  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_pat   <= '0;
      r_rem   <= '0;
      r_gap   <= '0;
      r_code  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_pat   <= w_pat;
      r_rem   <= w_rem;
      r_gap   <= w_gap;
      r_code  <= w_code;
      r_done  <= w_done;
    end
  end

endmodule

// File: tb/tb_morse_serializer.sv
// Directed bench for morse_serializer: main instance with
// TICK_DIV=4, second instance with TICK_DIV=1.
module tb_morse_serializer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  morse_serializer_if #(.PAT_W(16), .LEN_W(5)) bus0 ();
  morse_serializer_if #(.PAT_W(16), .LEN_W(5)) bus1 ();

  morse_serializer #(
    .PAT_W(16), .LEN_W(5), .TICK_DIV(4), .GAP_UNITS(3)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  morse_serializer #(
    .PAT_W(16), .LEN_W(5), .TICK_DIV(1), .GAP_UNITS(3)
  ) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {ready,busy,morse_code,done} of the main instance
  function automatic logic [3:0] st0();
    return {bus0.ready, bus0.busy, bus0.morse_code, bus0.done};
  endfunction

  function automatic logic [3:0] st1();
    return {bus1.ready, bus1.busy, bus1.morse_code, bus1.done};
  endfunction

  initial begin
    logic [3:0]  exp;
    logic [4:0]  bits;
    int          nbusy;
    int          ndone;

    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus0.pattern = '0; bus0.length = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus1.pattern = '0; bus1.length = '0;

    // power-up reset, before any clock edge
    #1;
    chk("por_main", 32'(st0()), 32'(4'b1000));
    chk("por_td1", 32'(st1()), 32'(4'b1000));
    #10 reset = 1'b1;
    tick();
    chk("idle_after_rst", 32'(st0()), 32'(4'b1000));

    // single transmission A800/5
    bits = 5'b10101;
    bus0.pattern = 16'hA800; bus0.length = 5'd5;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    nbusy = 0;
    for (int c = 0; c <= 32; c++) begin
      if (c < 20)      exp = {2'b01, bits[4 - c/4], 1'b0};
      else if (c < 32) exp = 4'b0100;
      else             exp = 4'b1001;
      chk($sformatf("a800_c%0d", c), 32'(st0()), 32'(exp));
      if (bus0.busy) nbusy++;
      tick();
    end
    chk("a800_busy_len", nbusy, 32);
    chk("a800_done_clr", 32'(st0()), 32'(4'b1000));

    // held start, inputs changed mid-transmission, back-to-back
    bus0.pattern = 16'hC000; bus0.length = 5'd2;
    bus0.start = 1'b1;
    tick();
    for (int c = 0; c <= 37; c++) begin
      if (c < 8)       exp = 4'b0110;
      else if (c < 20) exp = 4'b0100;
      else if (c == 20) exp = 4'b1001;
      else if (c < 25) exp = 4'b0110;
      else if (c < 37) exp = 4'b0100;
      else             exp = 4'b1001;
      chk($sformatf("b2b_c%0d", c), 32'(st0()), 32'(exp));
      if (c == 0) begin
        bus0.pattern = 16'h8000; bus0.length = 5'd1;
      end
      if (c == 21) bus0.start = 1'b0;
      tick();
    end

    // length=0 is ignored
    bus0.pattern = 16'hFFFF; bus0.length = 5'd0;
    bus0.start = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus0.done || bus0.busy) ndone++;
    end
    chk("len0_idle", 32'(st0()), 32'(4'b1000));
    chk("len0_no_resp", ndone, 0);
    bus0.start = 1'b0;

    // length=20 clamps to 16 units
    bus0.pattern = 16'hFFFF; bus0.length = 5'd20;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    nbusy = 0;
    for (int c = 0; c <= 76; c++) begin
      if (c < 64)      exp = 4'b0110;
      else if (c < 76) exp = 4'b0100;
      else             exp = 4'b1001;
      if (c % 8 == 0 || c >= 62)
        chk($sformatf("clamp_c%0d", c), 32'(st0()), 32'(exp));
      if (bus0.busy) nbusy++;
      tick();
    end
    chk("clamp_busy_len", nbusy, 76);

    // abort on last cycle of unit 3 (coincides with boundary)
    bus0.pattern = 16'hA800; bus0.length = 5'd5;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (11) tick();
    chk("abort_pre", 32'(st0()), 32'(4'b0110));
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    chk("abort_idle", 32'(st0()), 32'(4'b1000));
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus0.done || bus0.busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // abort while idle has no effect
    bus0.abort = 1'b1;
    tick();
    chk("abort_in_idle", 32'(st0()), 32'(4'b1000));
    bus0.abort = 1'b0;

    // TICK_DIV=1 instance: one unit per cycle
    bus1.pattern = 16'hA800; bus1.length = 5'd5;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c < 5)      exp = {2'b01, bits[4 - c], 1'b0};
      else if (c < 8) exp = 4'b0100;
      else            exp = 4'b1001;
      chk($sformatf("td1_c%0d", c), 32'(st1()), 32'(exp));
      tick();
    end

    // asynchronous reset mid-SEND
    bus0.pattern = 16'hFFFF; bus0.length = 5'd16;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (5) tick();
    chk("rst_pre", 32'(st0()), 32'(4'b0110));
    #2 reset = 1'b0;
    #1;
    chk("rst_async", 32'(st0()), 32'(4'b1000));
    #3 reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (bus0.done || bus0.busy) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_final", 32'(st0()), 32'(4'b1000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/morse_serializer.md
MORSE_SERIALIZER -- requirements
Module: morse_serializer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PAT_W, 16, pattern register width in symbol units (>=2).
- LEN_W, 5, width of length input; SHALL be >= clog2(PAT_W)+1.
- TICK_DIV, 25000000, clock cycles per symbol unit (>=1); 25000000 gives 0.5 s at 50 MHz.
- GAP_UNITS, 3, low units appended after each pattern (>=0).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only when ready=1.
- abort  in  1  synchronous cancel of an active transmission.
- pattern  in  PAT_W  on/off units, MSB transmitted first.
- length  in  LEN_W  number of units to send.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SEND or GAP.
- morse_code  out  1  registered serial output.
- done  out  1  one-cycle pulse on normal completion.

Function
REQ-003 FSM SHALL have states IDLE, SEND, GAP; ready=(IDLE), busy=(SEND|GAP).
REQ-004 IDLE: morse_code=0, unit-tick counter held at 0.
REQ-005 At a rising edge in IDLE with start=1 and length!=0, block SHALL capture pattern and eff_len=min(length,PAT_W), enter SEND, and drive morse_code=pattern[PAT_W-1] from that edge (zero-cycle latency after the sampling edge).
REQ-006 start=1 with length=0 SHALL be ignored: no state change, no done.
REQ-007 Tick counter SHALL count 0..TICK_DIV-1 and wrap; each wrap is a unit boundary; TICK_DIV=1 gives one unit per cycle.
REQ-008 In SEND, each unit boundary SHALL shift the captured pattern left by one (zero fill) and decrement the remaining-unit count; morse_code follows the new MSB.
REQ-009 The boundary ending unit eff_len SHALL enter GAP with morse_code=0 if GAP_UNITS>0, else enter IDLE.
REQ-010 GAP SHALL hold morse_code=0 for GAP_UNITS units, then enter IDLE.
REQ-011 done SHALL be 1 for exactly the first cycle after a normal SEND/GAP->IDLE transition, 0 otherwise.
REQ-012 start, pattern and length SHALL be ignored while busy=1; captured data SHALL NOT change mid-transmission.
REQ-013 start held high through done SHALL begin the next transmission on the edge ending the done cycle (back-to-back, no extra idle cycle).
REQ-014 abort=1 in SEND or GAP SHALL force IDLE at the next edge: morse_code=0, counters cleared, done not asserted; abort in IDLE has no effect; abort has priority over a simultaneous unit boundary.
REQ-015 Total busy duration SHALL equal (eff_len+GAP_UNITS)*TICK_DIV cycles.

Reset
REQ-016 reset=0 SHALL immediately, regardless of clock, force IDLE, clear all counters and captured pattern, and drive morse_code=0, busy=0, done=0, ready=1.
REQ-017 Reset asserted mid-transmission SHALL discard it with no done pulse; after release the block SHALL wait for a new start.

Verification (PAT_W=16, TICK_DIV=4, GAP_UNITS=3 unless stated)
REQ-018 Bench SHALL cover:
- Power-up reset -> morse_code=0, busy=0, done=0, ready=1 before any clock edge.
- start pulse, pattern=16'hA800, length=5 at edge k -> morse_code 1,0,1,0,1 each 4 cycles over cycles k..k+19, low k+20..k+31, done=1 only in cycle k+32, busy=1 for exactly 32 cycles.
- start held high, pattern/length changed while busy -> output unchanged; second transmission begins at edge ending done cycle.
- length=0 -> no response; length=20 with pattern=16'hFFFF -> 16 high units (64 cycles) then gap.
- abort=1 in unit 3 of SEND -> IDLE next edge, morse_code=0, no done; TICK_DIV=1 run -> one unit per cycle.
- reset=0 mid-SEND between clock edges -> outputs at reset values immediately; no done after release.
